// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and next-fetch-address selection for a single-issue core.
// Next pc priority: jump-register, then jump, then branch, then pc+1.
// With the MULTDIV_STALL_EN macro defined, a small IDLE/WAIT FSM launches the multiply/divide
// unit and holds the pc until its result is ready. Without it, the multdiv handshake outputs
// are tied low and the pc advances every cycle.
module pc_fetch_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] q_imem,
   input  logic        BR,
   input  logic        JP,
   input  logic        Jr,
   input  logic [31:0] rd_val,
   input  logic        data_resultRDY,
   output logic [11:0] address_imem,
   output logic [31:0] pc_plus_1,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        md_wb
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] next_pc;
   logic [31:0] br_offset;

   assign pc_plus_1 = pc_q + 32'd1;
   assign br_offset = {{15{q_imem[16]}}, q_imem[16:0]};

   // The fetch address reads as zero for as long as reset is held, even before the first edge.
   assign address_imem = reset ? 12'd0 : pc_q[11:0];

   // Select the control-flow target; all arithmetic wraps modulo 2^32.
   always_comb begin
      next_pc = pc_plus_1;
      if (Jr) begin
         next_pc = rd_val;
      end else if (JP) begin
         next_pc = {5'b0, q_imem[26:0]};
      end else if (BR) begin
         next_pc = pc_plus_1 + br_offset;
      end
   end

`ifdef MULTDIV_STALL_EN

   typedef enum logic [0:0] {StIdle, StWait} md_state_e;

   md_state_e state_q, state_d;
   logic      is_mul, is_div;

   assign is_mul = (q_imem[31:27] == 5'b00000) && (q_imem[6:2] == 5'b00110);
   assign is_div = (q_imem[31:27] == 5'b00000) && (q_imem[6:2] == 5'b00111);

   // The start pulses must coincide with the mul/div fetch, so the outputs decode from the
   // current state and instruction rather than being registered a cycle late.
   always_comb begin
      pc_d      = next_pc;
      state_d   = state_q;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      stall     = 1'b0;
      md_wb     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Branch/jump controls are irrelevant here: mul/div never redirects the pc.
            if (is_mul || is_div) begin
               ctrl_MULT = is_mul;
               ctrl_DIV  = is_div;
               stall     = 1'b1;
               pc_d      = pc_q;
               state_d   = StWait;
            end
         end
         StWait: begin
            if (data_resultRDY) begin
               md_wb   = 1'b1;
               pc_d    = pc_plus_1;
               state_d = StIdle;
            end else begin
               stall = 1'b1;
               pc_d  = pc_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (reset) begin
         ctrl_MULT = 1'b0;
         ctrl_DIV  = 1'b0;
         stall     = 1'b0;
         md_wb     = 1'b0;
      end
   end

   // Register pc and FSM state; reset abandons any pending multdiv operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= 32'd0;
         state_q <= StIdle;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

`else

   logic [5:0] unused_md_inputs;

   // Opcode bits and the ready strobe only matter to the multdiv FSM.
   assign unused_md_inputs = {data_resultRDY, q_imem[31:27]};

   assign ctrl_MULT = 1'b0;
   assign ctrl_DIV  = 1'b0;
   assign stall     = 1'b0;
   assign md_wb     = 1'b0;

   // Without the multdiv stall the pc simply takes the selected target every cycle.
   always_comb begin
      pc_d = next_pc;
   end

   // Register the pc.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= 32'd0;
      end else begin
         pc_q <= pc_d;
      end
   end

`endif

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port clock  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  in  1  synchronous active-high reset, sampled on rising clock.
REQ-003 SHALL have port q_imem  in  32  current instruction word.
REQ-004 SHALL have port BR  in  1  branch taken, from decode.
REQ-005 SHALL have port JP  in  1  jump/jal/bex taken, from decode.
REQ-006 SHALL have port Jr  in  1  jump-register, from decode.
REQ-007 SHALL have port rd_val  in  32  register value for jr target.
REQ-008 SHALL have port data_resultRDY  in  1  multdiv result valid.
REQ-009 SHALL have port address_imem  out  12  instruction fetch address, equal to pc[11:0].
REQ-010 SHALL have port pc_plus_1  out  32  pc+1, for the jal link write.
REQ-011 SHALL have port ctrl_MULT  out  1  one-cycle multiply start pulse.
REQ-012 SHALL have port ctrl_DIV  out  1  one-cycle divide start pulse.
REQ-013 SHALL have port stall  out  1  gates register-file write enable while a multdiv operation is pending.
REQ-014 SHALL have port md_wb  out  1  multdiv result writeback strobe.

Function
REQ-015 SHALL hold a 32-bit pc register; pc_plus_1 = pc+1 (mod 2^32), combinational.
REQ-016 SHALL compute next pc in this priority: Jr -> rd_val; else JP -> {5'b0, q_imem[26:0]}; else BR -> pc+1+sign-extend(q_imem[16:0]); else pc+1.
REQ-017 SHALL wrap all pc arithmetic modulo 2^32; branch offset -1 from pc 0 yields pc 0.
REQ-018 SHALL decode mul as opcode q_imem[31:27]=00000 with q_imem[6:2]=00110, and div as opcode 00000 with q_imem[6:2]=00111.
REQ-019 SHALL implement a multdiv FSM with states IDLE and WAIT.
REQ-020 IDLE, mul/div decoded: SHALL pulse ctrl_MULT or ctrl_DIV for exactly that cycle, assert stall, hold pc, and go to WAIT.
REQ-021 IDLE, not mul/div: SHALL load next pc every cycle with stall=0.
REQ-022 WAIT, data_resultRDY=0: SHALL hold pc and assert stall, with no ctrl pulse.
REQ-023 WAIT, data_resultRDY=1: SHALL assert md_wb=1 and stall=0 that cycle, load pc+1 at the clock edge, and return to IDLE.
REQ-024 data_resultRDY high in IDLE SHALL be ignored.
REQ-025 ctrl_MULT and ctrl_DIV SHALL never both be 1.
REQ-026 BR/JP/Jr SHALL be ignored while in WAIT, because the mul/div instruction is non-branching.

Reset
REQ-027 While reset=1 at the clock edge, SHALL set pc=0 and FSM=IDLE.
REQ-028 During reset, outputs SHALL be ctrl_MULT=0, ctrl_DIV=0, stall=0, md_wb=0, address_imem=0.
REQ-029 Reset asserted while in WAIT SHALL abandon the operation, with no md_wb on any later data_resultRDY until a new mul/div is issued.
REQ-030 Reset SHALL take priority over all next-pc sources.

Configuration
REQ-031 With MULTDIV_STALL_EN defined, SHALL implement the multdiv FSM per REQ-019..REQ-026.
REQ-032 With MULTDIV_STALL_EN undefined, SHALL omit the FSM and tie ctrl_MULT, ctrl_DIV, stall and md_wb to 0; pc SHALL advance per REQ-016 every cycle.

Verification
REQ-033 SHALL cover: reset, then 3 cycles of non-control instructions -> address_imem 0,1,2,3.
REQ-034 SHALL cover: pc=10, BR=1, q_imem[16:0]=17'h1FFFD (-3) -> next pc=8; pc=10, JP=1, T=27'd100 -> next pc=100.
REQ-035 SHALL cover: JP=1, Jr=1 and BR=1 together, rd_val=32'd55 -> next pc=55 (Jr wins).
REQ-036 SHALL cover: pc=4, mul issued, data_resultRDY arrives 4 cycles later -> ctrl_MULT high 1 cycle, pc=4 and stall=1 for 4 cycles, md_wb=1 on the ready cycle, then pc=5.
REQ-037 SHALL cover: div issued, reset asserted in WAIT, then data_resultRDY=1 -> pc=0, md_wb stays 0, FSM in IDLE.
REQ-038 SHALL cover: with MULTDIV_STALL_EN undefined, mul at pc=4 -> pc=5 next cycle, with all ctrl outputs 0.
